// File: rtl/coin_pulse_decoder.sv
// ---------------------------------------------------------------------------
// coin_pulse_decoder
//
// Purpose:
//   Turns the raw pulse train from a coin mechanism into one coin event per
//   inserted coin. The line is synchronised, short glitches are rejected,
//   and qualified pulses are counted. When the line has been idle for
//   COMMIT_TIMEOUT cycles after the last counted pulse, the count is
//   committed as a single event on a valid/ready output. If the event
//   register is still occupied at commit time, the new event is dropped and
//   a sticky lost flag is raised.
//
// Parameters:
//   MAX_PULSE_COUNT    largest legal pulse count per coin; more is an error
//   COMMIT_TIMEOUT     idle cycles after the last counted pulse before commit
//   MIN_ACTIVE_CYCLES  minimum consecutive active cycles for a pulse (>= 1)
//   IDLE_LEVEL         line level when no pulse is present
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   pulse_in      asynchronous coin pulse line
//   coin_ready    consumer accepts the pending coin event
//   coin_valid    coin event pending
//   coin_value    pulse count of the event (0 when coin_error)
//   coin_error    event had more than MAX_PULSE_COUNT pulses
//   coin_lost     sticky: a commit found coin_valid still occupied
//   counting_out  decoder is inside a pulse train (FSM not idle)
//   pulse_out     synchronised pulse line
// ---------------------------------------------------------------------------
module coin_pulse_decoder #(
  parameter int   MAX_PULSE_COUNT   = 50,
  parameter int   COMMIT_TIMEOUT    = 3_600_000,
  parameter int   MIN_ACTIVE_CYCLES = 4,
  parameter logic IDLE_LEVEL        = 1'b1,
  localparam int  COIN_WIDTH        = $clog2(MAX_PULSE_COUNT + 1),
  localparam int  TIMER_WIDTH       = $clog2(COMMIT_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse_in,
  input  logic                  coin_ready,
  output logic                  coin_valid,
  output logic [COIN_WIDTH-1:0] coin_value,
  output logic                  coin_error,
  output logic                  coin_lost,
  output logic                  counting_out,
  output logic                  pulse_out
);

  // The width counter only has to reach MIN_ACTIVE_CYCLES, where it saturates.
  localparam int WIDTH_BITS = $clog2(MIN_ACTIVE_CYCLES + 1);

  localparam logic [COIN_WIDTH-1:0]  COUNT_MAX = COIN_WIDTH'(MAX_PULSE_COUNT);
  localparam logic [TIMER_WIDTH-1:0] TIMER_END = TIMER_WIDTH'(COMMIT_TIMEOUT);
  localparam logic [WIDTH_BITS-1:0]  WIDTH_MIN = WIDTH_BITS'(MIN_ACTIVE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Synchroniser: three flops so s2 is safe to use everywhere.
  // -------------------------------------------------------------------------
  logic s0_reg;
  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_reg <= IDLE_LEVEL;
      s1_reg <= IDLE_LEVEL;
      s2_reg <= IDLE_LEVEL;
    end else begin
      s0_reg <= pulse_in;
      s1_reg <= s0_reg;
      s2_reg <= s1_reg;
    end
  end

  logic active;
  assign active    = (s2_reg != IDLE_LEVEL);
  assign pulse_out = s2_reg;

  // -------------------------------------------------------------------------
  // Pulse-train FSM and output event register.
  // -------------------------------------------------------------------------
  state_t                  state_reg;
  logic [COIN_WIDTH-1:0]   count_reg;
  logic [TIMER_WIDTH-1:0]  timer_reg;
  logic [WIDTH_BITS-1:0]   width_cnt_reg;
  logic                    ovf_reg;

  // Acceptance of the pending event in this cycle; a commit in the same
  // cycle may immediately reuse the freed slot.
  logic accept;
  assign accept = coin_valid && coin_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      timer_reg     <= '0;
      width_cnt_reg <= '0;
      ovf_reg       <= 1'b0;
      coin_valid    <= 1'b0;
      coin_value    <= '0;
      coin_error    <= 1'b0;
      coin_lost     <= 1'b0;
    end else begin
      // Consumer handshake; a commit below overrides this when it reloads.
      if (accept) begin
        coin_valid <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (active) begin
            state_reg     <= ACTIVE;
            width_cnt_reg <= WIDTH_BITS'(1);
          end
        end

        ACTIVE: begin
          // Timer is frozen while the line is active.
          if (active) begin
            if (width_cnt_reg < WIDTH_MIN) begin
              width_cnt_reg <= width_cnt_reg + WIDTH_BITS'(1);
            end
          end else if (width_cnt_reg >= WIDTH_MIN) begin
            // Qualified pulse: count it (or flag overflow) and restart the
            // idle timer from the trailing edge.
            if (count_reg < COUNT_MAX) begin
              count_reg <= count_reg + COIN_WIDTH'(1);
            end else begin
              ovf_reg <= 1'b1;
            end
            timer_reg <= '0;
            state_reg <= GAP;
          end else begin
            // Glitch: ignored entirely, the timer keeps its value so a
            // glitch cannot postpone the commit indefinitely.
            if (count_reg != '0) begin
              state_reg <= GAP;
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        GAP: begin
          if (active) begin
            state_reg     <= ACTIVE;
            width_cnt_reg <= WIDTH_BITS'(1);
          end else if (timer_reg == TIMER_END) begin
            state_reg <= COMMIT;
          end else begin
            timer_reg <= timer_reg + TIMER_WIDTH'(1);
          end
        end

        COMMIT: begin
          // The slot is free if empty or being accepted this very cycle.
          if (!coin_valid || coin_ready) begin
            coin_valid <= 1'b1;
            coin_value <= ovf_reg ? '0 : count_reg;
            coin_error <= ovf_reg;
          end else begin
            coin_lost <= 1'b1;
          end
          count_reg     <= '0;
          ovf_reg       <= 1'b0;
          timer_reg     <= '0;
          width_cnt_reg <= '0;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign counting_out = (state_reg != IDLE);

endmodule

// File: tb/tb_coin_pulse_decoder.sv
// ---------------------------------------------------------------------------
// tb_coin_pulse_decoder
//
// Directed bench for coin_pulse_decoder with a short timeout
// (COMMIT_TIMEOUT=20, MIN_ACTIVE_CYCLES=3, MAX_PULSE_COUNT=5, active-low).
// Inputs change 1 time unit after a rising edge and outputs are read at
// the same point, so "cyc" counts rising edges since time zero.
// Commit latency: pulse_in released just after edge k -> s2 high after
// edge k+3 -> coin_valid high after edge k+26.
// ---------------------------------------------------------------------------
module tb_coin_pulse_decoder;

  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          pulse_in;
  logic          coin_ready;
  logic          coin_valid;
  logic [CW-1:0] coin_value;
  logic          coin_error;
  logic          coin_lost;
  logic          counting_out;
  logic          pulse_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;
  int dt;

  coin_pulse_decoder #(
    .MAX_PULSE_COUNT  (5),
    .COMMIT_TIMEOUT   (20),
    .MIN_ACTIVE_CYCLES(3),
    .IDLE_LEVEL       (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pulse_in    (pulse_in),
    .coin_ready  (coin_ready),
    .coin_valid  (coin_valid),
    .coin_value  (coin_value),
    .coin_error  (coin_error),
    .coin_lost   (coin_lost),
    .counting_out(counting_out),
    .pulse_out   (pulse_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cyc %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cyc %0d)", tag, got, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // One active-low pulse of 'low' cycles followed by 'gap' idle cycles.
  task automatic pulse(input int low, input int gap);
    pulse_in = 1'b0;
    step(low);
    pulse_in = 1'b1;
    step(gap);
  endtask

  // Wait (bounded) for coin_valid; dt = edges since 'start'.
  task automatic wait_valid(input string tag, input int start, output int d);
    int n;
    n = 0;
    while (coin_valid !== 1'b1 && n < 80) begin
      step(1);
      n++;
    end
    check({tag, "_seen"}, {31'd0, coin_valid}, 32'd1);
    d = cyc - start;
  endtask

  initial begin
    rst        = 1'b1;
    pulse_in   = 1'b1;
    coin_ready = 1'b1;
    step(3);
    check("rst_valid", {31'd0, coin_valid}, 0);
    check("rst_value", {29'd0, coin_value}, 0);
    check("rst_error", {31'd0, coin_error}, 0);
    check("rst_lost",  {31'd0, coin_lost}, 0);
    check("rst_count", {31'd0, counting_out}, 0);
    check("rst_s2",    {31'd0, pulse_out}, 1);
    rst = 1'b0;
    step(2);

    // 1: three 4-cycle pulses, 6-cycle gaps.
    pulse(4, 6);
    pulse(4, 6);
    check("t1_busy", {31'd0, counting_out}, 1);
    check("t1_novalid", {31'd0, coin_valid}, 0);
    pulse_in = 1'b0;
    step(4);
    pulse_in = 1'b1;
    c0 = cyc;
    step(2);
    check("t1_s2_low", {31'd0, pulse_out}, 0);
    step(1);
    check("t1_s2_rise", {31'd0, pulse_out}, 1);
    wait_valid("t1", c0, dt);
    check("t1_lat", dt, 26);
    check("t1_value", {29'd0, coin_value}, 3);
    check("t1_error", {31'd0, coin_error}, 0);
    check("t1_idle", {31'd0, counting_out}, 0);
    step(1);
    check("t1_onecyc", {31'd0, coin_valid}, 0);

    // 2: 4,1,4 pattern, middle glitch ignored.
    pulse(4, 6);
    pulse(1, 6);
    pulse(4, 0);
    c0 = cyc;
    wait_valid("t2", c0, dt);
    check("t2_lat", dt, 26);
    check("t2_value", {29'd0, coin_value}, 2);
    check("t2_error", {31'd0, coin_error}, 0);
    step(2);

    // 2b: a glitch in the gap freezes the timer for 2 cycles, no reset.
    pulse_in = 1'b0;
    step(4);
    pulse_in = 1'b1;
    c0 = cyc;
    step(5);
    pulse(1, 0);
    wait_valid("t2b", c0, dt);
    check("t2b_lat", dt, 28);
    check("t2b_value", {29'd0, coin_value}, 1);
    step(2);

    // 3a: exactly MAX pulses is legal.
    repeat (4) pulse(4, 4);
    pulse(4, 0);
    c0 = cyc;
    wait_valid("t3a", c0, dt);
    check("t3a_value", {29'd0, coin_value}, 5);
    check("t3a_error", {31'd0, coin_error}, 0);
    step(2);

    // 3b: seven minimum-width (3-cycle) pulses overflow.
    repeat (6) pulse(3, 4);
    pulse(3, 0);
    c0 = cyc;
    wait_valid("t3b", c0, dt);
    check("t3b_lat", dt, 26);
    check("t3b_value", {29'd0, coin_value}, 0);
    check("t3b_error", {31'd0, coin_error}, 1);
    step(2);

    // 3c: next coin clean; a 2-cycle pulse is below the minimum.
    pulse(4, 6);
    pulse(2, 6);
    pulse(3, 0);
    c0 = cyc;
    wait_valid("t3c", c0, dt);
    check("t3c_value", {29'd0, coin_value}, 2);
    check("t3c_error", {31'd0, coin_error}, 0);
    step(2);

    // 4: consumer stalled, second commit is lost.
    coin_ready = 1'b0;
    pulse(4, 4);
    pulse(4, 0);
    c0 = cyc;
    wait_valid("t4a", c0, dt);
    check("t4a_value", {29'd0, coin_value}, 2);
    step(3);
    check("t4_hold", {31'd0, coin_valid}, 1);
    pulse(4, 4);
    pulse(4, 4);
    pulse(4, 0);
    c0 = cyc;
    begin
      int n;
      n = 0;
      while (coin_lost !== 1'b1 && n < 80) begin
        step(1);
        n++;
      end
    end
    check("t4_lost", {31'd0, coin_lost}, 1);
    check("t4_lost_lat", cyc - c0, 26);
    check("t4_valid", {31'd0, coin_valid}, 1);
    check("t4_value", {29'd0, coin_value}, 2);
    check("t4_error", {31'd0, coin_error}, 0);
    coin_ready = 1'b1;
    step(1);
    check("t4_drop", {31'd0, coin_valid}, 0);
    check("t4_sticky", {31'd0, coin_lost}, 1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    check("t4_lost_clr", {31'd0, coin_lost}, 0);

    // 5: ready arrives exactly in the second COMMIT cycle.
    coin_ready = 1'b0;
    pulse(4, 0);
    c0 = cyc;
    wait_valid("t5a", c0, dt);
    check("t5a_value", {29'd0, coin_value}, 1);
    repeat (3) pulse(4, 4);
    pulse(4, 0);
    c0 = cyc;
    step(25);
    check("t5_pre_valid", {31'd0, coin_valid}, 1);
    check("t5_pre_value", {29'd0, coin_value}, 1);
    coin_ready = 1'b1;
    step(1);
    check("t5_valid", {31'd0, coin_valid}, 1);
    check("t5_value", {29'd0, coin_value}, 4);
    check("t5_lost", {31'd0, coin_lost}, 0);
    step(1);
    check("t5_drop", {31'd0, coin_valid}, 0);
    check("t5_lost2", {31'd0, coin_lost}, 0);

    // 6: reset mid-train discards everything.
    pulse(4, 4);
    pulse(4, 4);
    rst = 1'b1;
    step(1);
    check("t6_rst_valid", {31'd0, coin_valid}, 0);
    check("t6_rst_value", {29'd0, coin_value}, 0);
    check("t6_rst_count", {31'd0, counting_out}, 0);
    step(2);
    rst = 1'b0;
    step(30);
    check("t6_noevent", {31'd0, coin_valid}, 0);
    check("t6_idle", {31'd0, counting_out}, 0);
    pulse(4, 0);
    c0 = cyc;
    wait_valid("t6", c0, dt);
    check("t6_lat", dt, 26);
    check("t6_value", {29'd0, coin_value}, 1);
    check("t6_error", {31'd0, coin_error}, 0);
    step(1);
    check("t6_drop", {31'd0, coin_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
